// File: rtl/rv_pkg.sv
// Shared definitions for the multicycle RV control sequencer: opcode constants,
// FSM state encoding and the latched instruction-class encoding.
package rv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  typedef enum logic [1:0] {
    CLS_R,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH
  } iclass_t;

endpackage

// File: rtl/rv_opcode_class.sv
// Combinational opcode classifier: maps a 7-bit opcode to an instruction class
// and a legal flag. Unknown opcodes report legal=0 with class R as a don't-care.
module rv_opcode_class
  import rv_pkg::*;
(
  input  logic [6:0] opcode,
  output iclass_t    cls,
  output logic       legal
);

  always_comb begin
    cls   = CLS_R;
    legal = 1'b1;
    case (opcode)
      OP_R:      cls = CLS_R;
      OP_LOAD:   cls = CLS_LOAD;
      OP_STORE:  cls = CLS_STORE;
      OP_BRANCH: cls = CLS_BRANCH;
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/rv_multicycle_seq.sv
// Multicycle control sequencer: FETCH/DECODE/EXEC/MEM/WB FSM with a sticky
// illegal-opcode trap and a wrapping retired-instruction counter.
module rv_multicycle_seq
  import rv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [6:0]  opcode,
  input  logic        branch_cond,
  input  logic        dmem_ack,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_src,
  output logic        reg_write,
  output logic        alu_src,
  output logic        mem_to_reg,
  output logic        mem_read,
  output logic        mem_write,
  output logic        halted,
  output logic [31:0] retired_cnt
);

  state_t  state, state_nxt;
  iclass_t cls_q, dec_cls;
  logic    dec_legal;
  logic    retire;

  rv_opcode_class u_class (
    .opcode (opcode),
    .cls    (dec_cls),
    .legal  (dec_legal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cls_q       <= CLS_R;
      halted      <= 1'b0;
      retired_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) begin
        if (dec_legal) cls_q  <= dec_cls;
        else           halted <= 1'b1;
      end
      if (retire) retired_cnt <= retired_cnt + 32'd1;
    end
  end

  always_comb begin
    state_nxt  = state;
    retire     = 1'b0;
    imem_req   = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;

    case (state)
      S_IDLE: begin
        if (run) state_nxt = S_FETCH;
      end

      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we     = 1'b1;
          pc_we     = 1'b1;
          state_nxt = S_DECODE;
        end
      end

      S_DECODE: begin
        state_nxt = dec_legal ? S_EXEC : S_TRAP;
      end

      S_EXEC: begin
        case (cls_q)
          CLS_R:      state_nxt = S_WB;
          CLS_LOAD,
          CLS_STORE: begin
            alu_src   = 1'b1;
            state_nxt = S_MEM;
          end
          CLS_BRANCH: begin
            pc_src = 1'b1;
            pc_we  = branch_cond;
            retire = 1'b1;
          end
          default:    state_nxt = S_TRAP;
        endcase
      end

      S_MEM: begin
        mem_read  = (cls_q == CLS_LOAD);
        mem_write = (cls_q == CLS_STORE);
        if (dmem_ack) begin
          if (cls_q == CLS_LOAD) state_nxt = S_WB;
          else                   retire    = 1'b1;
        end
      end

      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls_q == CLS_LOAD);
        retire     = 1'b1;
      end

      S_TRAP: ;

      default: state_nxt = S_IDLE;
    endcase

    // Retirement is the only point where run is re-sampled mid-stream.
    if (retire) state_nxt = run ? S_FETCH : S_IDLE;
  end

endmodule

// File: tb/tb_rv_multicycle_seq.sv
// Self-checking bench for rv_multicycle_seq: per-cycle expected control vectors
// and retired counts are queued as stimulus is driven and popped at the sample point.
module tb_rv_multicycle_seq;

  logic        clk = 1'b0;
  logic        rst, run, imem_ack, branch_cond, dmem_ack;
  logic [6:0]  opcode;
  logic        imem_req, ir_we, pc_we, pc_src, reg_write, alu_src;
  logic        mem_to_reg, mem_read, mem_write, halted;
  logic [31:0] retired_cnt;

  rv_multicycle_seq dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .imem_req    (imem_req),
    .imem_ack    (imem_ack),
    .opcode      (opcode),
    .branch_cond (branch_cond),
    .dmem_ack    (dmem_ack),
    .ir_we       (ir_we),
    .pc_we       (pc_we),
    .pc_src      (pc_src),
    .reg_write   (reg_write),
    .alu_src     (alu_src),
    .mem_to_reg  (mem_to_reg),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .halted      (halted),
    .retired_cnt (retired_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [9:0] C_IREQ  = 10'b10_0000_0000;
  localparam logic [9:0] C_IRWE  = 10'b01_0000_0000;
  localparam logic [9:0] C_PCWE  = 10'b00_1000_0000;
  localparam logic [9:0] C_PCSRC = 10'b00_0100_0000;
  localparam logic [9:0] C_RW    = 10'b00_0010_0000;
  localparam logic [9:0] C_ALU   = 10'b00_0001_0000;
  localparam logic [9:0] C_M2R   = 10'b00_0000_1000;
  localparam logic [9:0] C_MRD   = 10'b00_0000_0100;
  localparam logic [9:0] C_MWR   = 10'b00_0000_0010;
  localparam logic [9:0] C_HALT  = 10'b00_0000_0001;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_BAD    = 7'b0010011;

  typedef struct {
    string       tag;
    logic [9:0]  ctrl;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_cnt;
  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [9:0] ctrl_vec;
  assign ctrl_vec = {imem_req, ir_we, pc_we, pc_src, reg_write, alu_src,
                     mem_to_reg, mem_read, mem_write, halted};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, queue the expectation,
  // then pop and compare at the falling edge.
  task automatic cyc(input string tag, input logic rs, input logic rn, input logic ia,
                     input logic da, input logic bc, input logic [6:0] op,
                     input logic [9:0] ctrl);
    exp_t e;
    @(posedge clk);
    #1;
    rst = rs; run = rn; imem_ack = ia; dmem_ack = da; branch_cond = bc; opcode = op;
    e.tag = tag; e.ctrl = ctrl; e.cnt = model_cnt;
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_ctrl"}, {22'd0, ctrl_vec}, {22'd0, e.ctrl});
      check({e.tag, "_cnt"}, retired_cnt, e.cnt);
    end
  endtask

  // Runs one legal instruction starting in FETCH; run is held at rk throughout.
  task automatic instr(input string nm, input logic [6:0] op, input int unsigned iw,
                       input int unsigned dw, input logic bc, input logic rk);
    logic ld, st, br;
    ld = (op == OPC_LOAD);
    st = (op == OPC_STORE);
    br = (op == OPC_BRANCH);
    for (int unsigned i = 0; i < iw; i++)
      cyc({nm, "_fwait"}, 1'b0, rk, 1'b0, 1'b0, 1'b0, op, C_IREQ);
    cyc({nm, "_fack"}, 1'b0, rk, 1'b1, 1'b0, 1'b0, op, C_IREQ | C_IRWE | C_PCWE);
    cyc({nm, "_dec"}, 1'b0, rk, 1'b0, 1'b0, 1'b0, op, '0);
    if (br) begin
      cyc({nm, "_exec"}, 1'b0, rk, 1'b0, 1'b0, bc, op, C_PCSRC | (bc ? C_PCWE : 10'd0));
      model_cnt = model_cnt + 32'd1;
      return;
    end
    cyc({nm, "_exec"}, 1'b0, rk, 1'b0, 1'b0, 1'b0, op, (ld | st) ? C_ALU : 10'd0);
    if (ld | st) begin
      for (int unsigned i = 0; i < dw; i++)
        cyc({nm, "_mwait"}, 1'b0, rk, 1'b0, 1'b0, 1'b0, op, ld ? C_MRD : C_MWR);
      cyc({nm, "_mack"}, 1'b0, rk, 1'b0, 1'b1, 1'b0, op, ld ? C_MRD : C_MWR);
      if (st) begin
        model_cnt = model_cnt + 32'd1;
        return;
      end
    end
    cyc({nm, "_wb"}, 1'b0, rk, 1'b0, 1'b0, 1'b0, op, C_RW | (ld ? C_M2R : 10'd0));
    model_cnt = model_cnt + 32'd1;
  endtask

  initial begin
    model_cnt = '0;
    rst = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    branch_cond = 1'b0; opcode = OPC_R;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ctrl", {22'd0, ctrl_vec}, 32'd0);
    check("reset_cnt", retired_cnt, 32'd0);

    cyc("idle0", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, OPC_R, '0);
    instr("load", OPC_LOAD, 0, 0, 1'b0, 1'b1);
    instr("br_t", OPC_BRANCH, 0, 0, 1'b1, 1'b1);
    instr("br_nt", OPC_BRANCH, 0, 0, 1'b0, 1'b1);
    instr("store_w", OPC_STORE, 3, 2, 1'b0, 1'b1);
    instr("rtype", OPC_R, 0, 0, 1'b0, 1'b1);

    // Reset arriving in MEM together with dmem_ack and run must win.
    cyc("ldr_fack", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, OPC_LOAD, C_IREQ | C_IRWE | C_PCWE);
    cyc("ldr_dec", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, OPC_LOAD, '0);
    cyc("ldr_exec", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, OPC_LOAD, C_ALU);
    cyc("ldr_mem_rst", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, OPC_LOAD, C_MRD);
    model_cnt = '0;
    cyc("after_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, OPC_LOAD, '0);

    // Counter wrap: preload while idle, where the counter cannot move.
    force dut.retired_cnt = 32'hFFFF_FFFF;
    #1 release dut.retired_cnt;
    model_cnt = 32'hFFFF_FFFF;
    cyc("idle_wrap", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, OPC_R, '0);
    instr("r_wrap", OPC_R, 0, 0, 1'b0, 1'b0);
    cyc("idle_after_wrap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, OPC_R, '0);
    cyc("idle_hold", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, OPC_R, '0);

    // Illegal opcode: trap is sticky with run held high until reset.
    cyc("bad_fack", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, OPC_BAD, C_IREQ | C_IRWE | C_PCWE);
    cyc("bad_dec", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, OPC_BAD, '0);
    for (int i = 0; i < 10; i++)
      cyc("trap", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, OPC_R, C_HALT);
    cyc("trap_rst", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, OPC_R, C_HALT);
    model_cnt = '0;
    cyc("post_trap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, OPC_R, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv_multicycle_seq.md
RV_MULTICYCLE_SEQ -- requirements
Module: rv_multicycle_seq

Interface
REQ-001 SHALL have ports: clk in 1, system clock; rst in 1, synchronous active-high reset.
REQ-002 SHALL have run in 1: start/continue execution; sampled in IDLE and at each retirement.
REQ-003 SHALL have imem_req out 1 (fetch request) and imem_ack in 1 (instruction word valid this cycle).
REQ-004 SHALL have opcode in 7, from the instruction register; valid from DECODE onward.
REQ-005 SHALL have branch_cond in 1, datapath compare result; valid in EXEC.
REQ-006 SHALL have dmem_ack in 1, data memory access complete this cycle.
REQ-007 SHALL have outputs, each 1 bit: ir_we, pc_we, pc_src (0 = PC+4, 1 = branch target), reg_write, alu_src, mem_to_reg, mem_read, mem_write.
REQ-008 SHALL have halted out 1 (sticky illegal-opcode trap) and retired_cnt out 32 (retired-instruction count).

Function
REQ-009 SHALL implement the FSM states IDLE, FETCH, DECODE, EXEC, MEM, WB and TRAP.
REQ-010 IDLE: all control outputs 0; run=1 -> FETCH at the next edge.
REQ-011 FETCH: imem_req=1 until imem_ack; in the imem_ack cycle ir_we=1, pc_we=1, pc_src=0 -> DECODE; otherwise stay in FETCH.
REQ-012 DECODE: one cycle; opcode is latched into a class register (R 0110011, LOAD 0000011, STORE 0100011, BRANCH 1100011); legal -> EXEC; any other opcode -> TRAP.
REQ-013 EXEC: alu_src=1 for LOAD/STORE, 0 for R/BRANCH; R -> WB; LOAD/STORE -> MEM.
REQ-014 EXEC, BRANCH: pc_src=1, pc_we=branch_cond in the same cycle; the instruction retires.
REQ-015 MEM: mem_read=1 (LOAD) or mem_write=1 (STORE), held until and including the dmem_ack cycle; LOAD -> WB; STORE retires.
REQ-016 WB: reg_write=1 for exactly one cycle; mem_to_reg=1 for LOAD, 0 for R; the instruction retires.
REQ-017 Retirement: retired_cnt increments by 1 at the edge ending the retiring state; next state is FETCH if run=1, else IDLE.
REQ-018 run deassertion mid-instruction SHALL NOT abort the instruction; it takes effect only at retirement.
REQ-019 retired_cnt SHALL wrap from 0xFFFFFFFF to 0x00000000 without a flag.
REQ-020 TRAP: halted=1, all other control outputs 0, no retirement; leaves TRAP only on rst.
REQ-021 Outputs SHALL depend only on state, the class register, imem_ack and branch_cond; no other combinational input-to-output paths.
REQ-022 At most one of mem_read and mem_write SHALL be 1 in any cycle; reg_write SHALL be 0 outside WB.
REQ-023 Latency, zero-wait memories: R = 4 cycles, LOAD = 5, STORE = 4, BRANCH = 3, FETCH through retirement inclusive.

Reset
REQ-024 rst=1 at a clk edge SHALL force the state to IDLE, the class register to R, halted=0 and retired_cnt=0.
REQ-025 Reset during any state, including mid-FETCH or mid-MEM, SHALL abandon the instruction with no retirement; all control outputs are 0 in the first cycle after reset.
REQ-026 rst SHALL take priority over every other input, including a simultaneous imem_ack, dmem_ack or run.

Structure
REQ-027 A shared package rv_pkg SHALL hold the opcode constants, the state enum and the class encoding.
REQ-028 A combinational sub-module rv_opcode_class SHALL map opcode to {class, legal}; the FSM and counter stay in rv_multicycle_seq.

Verification
REQ-029 LOAD 0000011, acks immediate, run=1 -> states F,D,E,M,W over 5 cycles; mem_read=1 in M, reg_write=1 and mem_to_reg=1 in W; retired_cnt 0->1.
REQ-030 BRANCH, branch_cond=1 then 0 -> EXEC cycle shows pc_src=1 with pc_we=1 and then 0 respectively; no reg_write; count +2.
REQ-031 imem_ack delayed 3 cycles, dmem_ack delayed 2 (STORE) -> imem_req high 4 cycles; mem_write high 3 cycles; a single ir_we pulse.
REQ-032 Opcode 0010011 -> TRAP after DECODE; halted=1; count unchanged; stays in TRAP across 10 cycles with run=1 until rst.
REQ-033 rst asserted in MEM with dmem_ack=1 in the same cycle -> IDLE next cycle, count=0, mem_read=0, no retirement.
REQ-034 retired_cnt preloaded (forced) to 0xFFFFFFFF, one R-type -> 0x00000000; run=0 during EXEC -> WB completes, then IDLE.
